// File: rtl/led_pkg.sv
// Shared types and constants for the LED-cube scan-refresh driver.
package led_pkg;

  localparam int unsigned NUM_LANES       = 12;
  localparam int unsigned NUM_ROWS        = 16;
  localparam int unsigned CHUNK_W         = 32;
  localparam int unsigned ADDR_W          = 4;
  localparam int unsigned ROW_W           = $clog2(NUM_ROWS);
  localparam int unsigned PANEL_W         = 2;
  localparam int unsigned LANES_PER_PANEL = 3;

  typedef enum logic [1:0] {
    LOAD,
    SHIFT,
    LATCH,
    DISPLAY
  } led_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [CHUNK_W-1:0] data;
  } chunk_wr_t;

  typedef logic [NUM_LANES-1:0][CHUNK_W-1:0] lane_words_t;

  // All-ones on the three RGB lanes of the selected panel, zero elsewhere.
  function automatic lane_words_t test_pattern(input logic [PANEL_W-1:0] panel);
    lane_words_t pat;
    pat = '0;
    for (int unsigned k = 0; k < NUM_LANES; k++) begin
      if (PANEL_W'(k / LANES_PER_PANEL) == panel) begin
        pat[k] = '1;
      end
    end
    return pat;
  endfunction

endpackage

// File: rtl/led_chunk_buffer.sv
// Row shadow buffer: one 32-bit chunk per lane, host-writable, read in parallel.
module led_chunk_buffer
  import led_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  chunk_wr_t   wr,
  output lane_words_t chunks
);

  // Addresses past the last lane match no entry and are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      chunks <= '0;
    end else if (wr_en) begin
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
        if (wr.addr == ADDR_W'(i)) begin
          chunks[i] <= wr.data;
        end
      end
    end
  end

endmodule

// File: rtl/led_controller.sv
// Scan-refresh driver: snapshots the chunk buffer, shifts it out on 12 lanes,
// latches the drivers and enables the addressed row, forever.
module led_controller
  import led_pkg::*;
#(
  parameter int unsigned SHIFT_BITS     = 32,
  parameter int unsigned DISPLAY_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 test_panel_select_n,
  input  logic [CHUNK_W-1:0]   chunk_data,
  input  logic [ADDR_W-1:0]    chunk_addr,
  input  logic                 chunk_write_enable,
  input  logic [ROW_W-1:0]     row_addr,
  input  logic [PANEL_W-1:0]   panel_addr,
  output logic                 serial_clk,
  output logic                 latch_enable,
  output logic                 output_enable_n,
  output logic [NUM_LANES-1:0] serial_data_out,
  output logic [NUM_ROWS-1:0]  row_select_n
);

  localparam int unsigned SHIFT_CYCLES = 2 * SHIFT_BITS;
  localparam int unsigned CNT_MAX      = (SHIFT_CYCLES > DISPLAY_CYCLES) ? SHIFT_CYCLES : DISPLAY_CYCLES;
  localparam int unsigned CNT_W        = $clog2(CNT_MAX);

  led_state_e           state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  lane_words_t          shreg, shreg_nxt;
  logic [ROW_W-1:0]     row_q, row_q_nxt;
  logic                 lit, lit_nxt;

  logic                 sclk_nxt;
  logic                 latch_nxt;
  logic                 oe_n_nxt;
  logic [NUM_LANES-1:0] sdo_nxt;
  logic [NUM_ROWS-1:0]  rsel_nxt;

  chunk_wr_t            chunk_wr;
  lane_words_t          chunks;
  lane_words_t          load_words;

  assign chunk_wr = chunk_wr_t'{addr: chunk_addr, data: chunk_data};

  led_chunk_buffer u_buf (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (chunk_write_enable),
    .wr     (chunk_wr),
    .chunks (chunks)
  );

  assign load_words = test_panel_select_n ? chunks : test_pattern(panel_addr);

  // Outputs are computed for the state being entered so they line up with it.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    shreg_nxt = shreg;
    row_q_nxt = row_q;
    lit_nxt   = lit;
    sclk_nxt  = 1'b0;
    latch_nxt = 1'b0;
    oe_n_nxt  = ~lit;
    sdo_nxt   = serial_data_out;
    rsel_nxt  = row_select_n;

    case (state)
      LOAD: begin
        state_nxt = SHIFT;
        cnt_nxt   = '0;
        shreg_nxt = load_words;
        row_q_nxt = row_addr;
        for (int unsigned k = 0; k < NUM_LANES; k++) begin
          sdo_nxt[k] = load_words[k][CHUNK_W-1];
        end
      end
      SHIFT: begin
        if (cnt == CNT_W'(SHIFT_CYCLES - 1)) begin
          state_nxt = LATCH;
          cnt_nxt   = '0;
          latch_nxt = 1'b1;
          oe_n_nxt  = 1'b1;
          rsel_nxt  = ~(NUM_ROWS'(1) << row_q);
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
          if (!cnt[0]) begin
            sclk_nxt = 1'b1;
          end else begin
            // Falling half: advance every lane to its next bit, MSB first.
            for (int unsigned k = 0; k < NUM_LANES; k++) begin
              shreg_nxt[k] = {shreg[k][CHUNK_W-2:0], 1'b0};
              sdo_nxt[k]   = shreg[k][CHUNK_W-2];
            end
          end
        end
      end
      LATCH: begin
        state_nxt = DISPLAY;
        cnt_nxt   = '0;
        lit_nxt   = 1'b1;
        oe_n_nxt  = 1'b0;
      end
      DISPLAY: begin
        oe_n_nxt = 1'b0;
        if (cnt == CNT_W'(DISPLAY_CYCLES - 1)) begin
          state_nxt = LOAD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = LOAD;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= LOAD;
      cnt             <= '0;
      shreg           <= '0;
      row_q           <= '0;
      lit             <= 1'b0;
      serial_clk      <= 1'b0;
      latch_enable    <= 1'b0;
      output_enable_n <= 1'b1;
      serial_data_out <= '0;
      row_select_n    <= '1;
    end else begin
      state           <= state_nxt;
      cnt             <= cnt_nxt;
      shreg           <= shreg_nxt;
      row_q           <= row_q_nxt;
      lit             <= lit_nxt;
      serial_clk      <= sclk_nxt;
      latch_enable    <= latch_nxt;
      output_enable_n <= oe_n_nxt;
      serial_data_out <= sdo_nxt;
      row_select_n    <= rsel_nxt;
    end
  end

endmodule

// File: tb/tb_led_controller.sv
// Directed bench for led_controller: frame-by-frame capture of lane data,
// timing of serial_clk / latch / blanking, row select and reset behaviour.
module tb_led_controller;

  logic        clk;
  logic        reset;
  logic        test_panel_select_n;
  logic [31:0] chunk_data;
  logic [3:0]  chunk_addr;
  logic        chunk_write_enable;
  logic [3:0]  row_addr;
  logic [1:0]  panel_addr;
  logic        serial_clk;
  logic        latch_enable;
  logic        output_enable_n;
  logic [11:0] serial_data_out;
  logic [15:0] row_select_n;

  int          n_checks;
  int          n_errors;
  logic [31:0] model_buf [12];

  led_controller dut (
    .clk                 (clk),
    .reset               (reset),
    .test_panel_select_n (test_panel_select_n),
    .chunk_data          (chunk_data),
    .chunk_addr          (chunk_addr),
    .chunk_write_enable  (chunk_write_enable),
    .row_addr            (row_addr),
    .panel_addr          (panel_addr),
    .serial_clk          (serial_clk),
    .latch_enable        (latch_enable),
    .output_enable_n     (output_enable_n),
    .serial_data_out     (serial_data_out),
    .row_select_n        (row_select_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check($sformatf("%s serial_clk", tag), 32'(serial_clk), 32'h0);
    check($sformatf("%s latch_enable", tag), 32'(latch_enable), 32'h0);
    check($sformatf("%s output_enable_n", tag), 32'(output_enable_n), 32'h1);
    check($sformatf("%s serial_data_out", tag), 32'(serial_data_out), 32'h0);
    check($sformatf("%s row_select_n", tag), 32'(row_select_n), 32'h0000_FFFF);
  endtask

  // Entered at the negedge inside a LOAD cycle; returns at the negedge of the next LOAD.
  task automatic run_frame(input string fid, input logic [3:0] row, input logic tmode_n,
                           input logic [1:0] pa, input int wr_off, input logic [3:0] wa,
                           input logic [31:0] wd, input logic first, input logic [15:0] exp_rsel);
    logic [31:0] exp_lane [12];
    logic [31:0] cap [12];
    logic [11:0] d0;
    logic        prev_sclk;
    logic        oe_n_load, oe_n_latch, sclk_latch;
    logic [15:0] rsel;
    int          rises, latch_cnt, latch_off, pre_oe_ones, disp_oe_ones, sclk_bad, unstable;
    int          j, bi;

    row_addr            = row;
    test_panel_select_n = tmode_n;
    panel_addr          = pa;
    for (int k = 0; k < 12; k++) begin
      if (tmode_n) exp_lane[k] = model_buf[k];
      else         exp_lane[k] = ((k / 3) == int'(pa)) ? 32'hFFFF_FFFF : 32'h0;
      cap[k] = 32'h0;
    end
    d0 = '0; prev_sclk = serial_clk;
    oe_n_load = 1'bx; oe_n_latch = 1'bx; sclk_latch = 1'bx; rsel = 'x;
    rises = 0; latch_cnt = 0; latch_off = -1; pre_oe_ones = 0; disp_oe_ones = 0;
    sclk_bad = 0; unstable = 0;

    for (int off = 0; off < 130; off++) begin
      chunk_write_enable = (off == wr_off);
      if (off == wr_off) begin
        chunk_addr = wa;
        chunk_data = wd;
        if (int'(wa) < 12) model_buf[wa] = wd;
      end
      if (off == 10) begin
        row_addr            = ~row;
        test_panel_select_n = ~tmode_n;
        panel_addr          = ~pa;
      end
      if (off == 0) oe_n_load = output_enable_n;
      if (off <= 64 && output_enable_n === 1'b1) pre_oe_ones++;
      if (off >= 1 && off <= 64) begin
        j  = off - 1;
        bi = j / 2;
        if ((j % 2) == 0) begin
          if (serial_clk !== 1'b0) sclk_bad++;
          d0 = serial_data_out;
        end else begin
          if (serial_clk !== 1'b1) sclk_bad++;
          if (serial_data_out !== d0) unstable++;
          for (int k = 0; k < 12; k++) cap[k][31-bi] = serial_data_out[k];
        end
      end
      if (serial_clk === 1'b1 && prev_sclk === 1'b0) rises++;
      prev_sclk = serial_clk;
      if (latch_enable === 1'b1) begin
        latch_cnt++;
        latch_off = off;
      end
      if (off == 65) begin
        oe_n_latch = output_enable_n;
        sclk_latch = serial_clk;
        rsel       = row_select_n;
      end
      if (off >= 66 && output_enable_n !== 1'b0) disp_oe_ones++;
      @(negedge clk);
    end
    chunk_write_enable = 1'b0;

    for (int k = 0; k < 12; k++) begin
      check($sformatf("%s lane%0d", fid, k), cap[k], exp_lane[k]);
    end
    check($sformatf("%s sclk_rises", fid), 32'(rises), 32'd32);
    check($sformatf("%s sclk_phase", fid), 32'(sclk_bad), 32'd0);
    check($sformatf("%s data_stable", fid), 32'(unstable), 32'd0);
    check($sformatf("%s latch_count", fid), 32'(latch_cnt), 32'd1);
    check($sformatf("%s latch_cycle", fid), 32'(latch_off + 1), 32'd66);
    check($sformatf("%s oe_n_in_latch", fid), 32'(oe_n_latch), 32'h1);
    check($sformatf("%s sclk_in_latch", fid), 32'(sclk_latch), 32'h0);
    check($sformatf("%s row_select_n", fid), 32'(rsel), 32'(exp_rsel));
    check($sformatf("%s oe_n_at_load", fid), 32'(oe_n_load), first ? 32'h1 : 32'h0);
    check($sformatf("%s oe_n_high_pre_latch", fid), 32'(pre_oe_ones), first ? 32'd65 : 32'd0);
    check($sformatf("%s oe_n_high_display", fid), 32'(disp_oe_ones), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks            = 0;
    n_errors            = 0;
    reset               = 1'b1;
    test_panel_select_n = 1'b1;
    chunk_data          = 32'h0;
    chunk_addr          = 4'h0;
    chunk_write_enable  = 1'b0;
    row_addr            = 4'h0;
    panel_addr          = 2'h0;
    for (int k = 0; k < 12; k++) model_buf[k] = 32'h0;

    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_reset_outputs("reset");

    //        id    row   tmode pa    wr_off wa     wd             first rsel
    run_frame("f1", 4'd0,  1'b1, 2'd0, 100,  4'd0,  32'h8000_0001, 1'b1, 16'hFFFE);
    run_frame("f2", 4'd3,  1'b1, 2'd0, 20,   4'd13, 32'hFFFF_FFFF, 1'b0, 16'hFFF7);
    run_frame("f3", 4'd5,  1'b1, 2'd0, 50,   4'd5,  32'hCAFE_F00D, 1'b0, 16'hFFDF);
    run_frame("f4", 4'd15, 1'b1, 2'd0, 0,    4'd5,  32'h1234_5678, 1'b0, 16'h7FFF);
    run_frame("f5", 4'd8,  1'b1, 2'd0, -1,   4'd0,  32'h0,         1'b0, 16'hFEFF);
    run_frame("f6", 4'd1,  1'b0, 2'd3, -1,   4'd0,  32'h0,         1'b0, 16'hFFFD);
    run_frame("f7", 4'd12, 1'b0, 2'd0, -1,   4'd0,  32'h0,         1'b0, 16'hEFFF);
    run_frame("f8", 4'd2,  1'b1, 2'd0, -1,   4'd0,  32'h0,         1'b0, 16'hFFFB);

    // Reset in the high half of a shift bit while a row is lit.
    row_addr            = 4'd4;
    test_panel_select_n = 1'b0;
    panel_addr          = 2'd0;
    repeat (34) @(negedge clk);
    check("midshift serial_clk", 32'(serial_clk), 32'h1);
    check("midshift serial_data_out", 32'(serial_data_out), 32'h007);
    check("midshift output_enable_n", 32'(output_enable_n), 32'h0);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("midreset");
    reset = 1'b0;
    for (int k = 0; k < 12; k++) model_buf[k] = 32'h0;

    run_frame("f9", 4'd6,  1'b1, 2'd0, -1,   4'd0,  32'h0,         1'b1, 16'hFFBF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/led_controller.md
Name: led_controller

Overview:
- Scan-refresh driver for one LED-cube panel group: 4 panels × RGB = 12 serial lanes, with 16 multiplexed rows.
- The host writes 32-bit chunks into a row shadow buffer.
- The controller continuously shifts the buffer out on 12 lanes, latches it, and enables the addressed row.
- Sits between the host/register interface and the external constant-current shift-register drivers and row FETs.

Parameters:
- SHIFT_BITS, 32, bits shifted per lane per row (equals chunk width).
- DISPLAY_CYCLES, 64, clk cycles in DISPLAY state per row.

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  synchronous, active-high reset
- test_panel_select_n  in  1  0 = test pattern on the panel chosen by panel_addr
- chunk_data  in  32  chunk write data
- chunk_addr  in  4  chunk index; 0..11 = lane number, 12..15 ignored
- chunk_write_enable  in  1  write strobe, one chunk per cycle while high
- row_addr  in  4  row shown for the buffer being shifted
- panel_addr  in  2  panel selected for test pattern (lanes 3p..3p+2)
- serial_clk  out  1  driver shift clock, clk/2
- latch_enable  out  1  driver latch pulse
- output_enable_n  out  1  driver blanking, active low
- serial_data_out  out  12  lane data, bit k = lane k
- row_select_n  out  16  one-hot-low row drive

Behaviour:
- Reset state and outputs:
  - serial_clk=0, latch_enable=0, output_enable_n=1, serial_data_out=0, row_select_n=16'hFFFF.
  - All 12 buffer chunks cleared to 0; FSM goes to LOAD.
- Writes:
  - Every cycle with chunk_write_enable=1 and chunk_addr<12 sets buf[chunk_addr] <= chunk_data.
  - addr 12..15: no effect.
  - Writes are accepted in every FSM state.
- FSM states: LOAD → SHIFT → LATCH → DISPLAY → LOAD, repeating forever.
- LOAD (1 cycle):
  - For each lane k, shreg[k] <= buf[k].
  - In test mode (test_panel_select_n=0), lanes 3*panel_addr..3*panel_addr+2 get 32'hFFFFFFFF and all other lanes get 0.
  - Sample row_q <= row_addr.
  - A write in the same cycle updates buf; the snapshot takes the old value.
- SHIFT (2*SHIFT_BITS cycles), for bit i = 0..31:
  - Cycle 2i: serial_clk=0, serial_data_out[k]=shreg[k][31-i] (MSB first).
  - Cycle 2i+1: serial_clk=1 with data held stable.
  - Drivers sample on the serial_clk rising edge; serial_clk ends at 0.
- LATCH (1 cycle):
  - latch_enable=1, output_enable_n=1, serial_clk=0.
  - row_select_n <= ~(16'b1 << row_q), registered this cycle.
- DISPLAY (DISPLAY_CYCLES cycles): output_enable_n=0, latch_enable=0.
- output_enable_n is also 0 during LOAD/SHIFT once the first LATCH has occurred, so the previous row stays lit.
- Before the first LATCH after reset, output_enable_n=1.
- Row update: row_addr changes during SHIFT/LATCH/DISPLAY have no effect until the next LOAD.
- Mode switch: test_panel_select_n and panel_addr take effect only at LOAD.
- Reset mid-operation: outputs return to reset values the next cycle and the buffer is cleared.
- Row period = 1 + 64 + 1 + DISPLAY_CYCLES = 130 cycles at default.
- All outputs are registered.

Decomposition:
- Shared package led_pkg holds:
  - NUM_LANES=12, NUM_ROWS=16, CHUNK_W=32.
  - State enum {LOAD, SHIFT, LATCH, DISPLAY}.
- One sub-module, led_chunk_buffer: 12×32 register file with write port and parallel snapshot/clear.

Test Plan:
- Reset for 5 cycles, release: outputs hold reset values until the first LATCH, which occurs at cycle 66 after release; serial_data_out=0 throughout the first frame.
- Normal mode (test_panel_select_n=1), write buf[0]=32'h80000001, row_addr=3:
  - During the following SHIFT, lane0 is 1 at bits 0 and 31 and 0 elsewhere; lanes 1..11 are 0.
  - After LATCH, row_select_n=16'hFFF7.
- Test mode, panel_addr=3: serial_data_out=12'hE00 on every bit; panel_addr=0 gives 12'h007, with buffer contents ignored.
- Write chunk_addr=13 with 32'hFFFFFFFF: no lane changes.
- Write buf[5] in the same cycle as LOAD: the current row shifts the old value and the next row shifts the new one.
- Check timing:
  - serial_clk has exactly 32 rising edges per row.
  - latch_enable is high exactly 1 cycle per 130.
  - output_enable_n is high during LATCH.
  - Assert reset mid-SHIFT: all outputs return to reset values the next cycle.
